fetch_prefetch_buffer: RTL and testbench
========================================

// Module: fetch_prefetch_buffer
// PURPOSE
//  Fetch stage with prefetch queue, upstream of the R-type decode/execute unit in the single-clock datapath.
//  Owns the PC and issues sequential reads to a synchronous instruction memory (1-cycle read latency).
//  Buffers returned words with their PC in a small FIFO; hands them to decode via a valid/ready handshake.
//  Branch redirect flushes the queue and any in-flight read.
// PARAMETERS
//  DEPTH     4        FIFO entries (power of 2, >=2)
//  ADDR_W    32       PC / memory address width
//  DATA_W    32       instruction width
//  RESET_PC  32'h0    PC value loaded on reset
// PORTS
//  clk_fb          in   1       clock, rising edge
//  rst_fb          in   1       reset, asynchronous, active-high
//  imem_req        out  1       read request this cycle
//  imem_addr       out  ADDR_W  read address (= PC), word aligned
//  imem_rdata      in   DATA_W  read data, valid the cycle after imem_req
//  redirect_valid  in   1       branch/jump taken; flush and reload PC
//  redirect_pc     in   ADDR_W  new PC; bits [1:0] ignored (forced 0)
//  instr_out       out  DATA_W  head-of-queue instruction
//  pc_out          out  ADDR_W  PC of instr_out
//  instr_valid     out  1       queue non-empty
//  instr_ready     in   1       decode accepts head this cycle
//  buf_count       out  $clog2(DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (async): PC=RESET_PC, FIFO empty, inflight=0, buf_count=0, instr_valid=0, imem_req=0 while asserted.
//  instr_out/pc_out are don't-care while instr_valid=0; the bench drives/checks them as 0 after reset.
//  Request rule: imem_req = !redirect_valid && (buf_count + inflight) < DEPTH.
//  On an issued request: PC <= PC+4 (wraps mod 2^ADDR_W). inflight <= imem_req every cycle.
//  Response: if inflight && !redirect_valid, push {imem_rdata, PC_of_request} at the next edge.
//  Pop: instr_valid && instr_ready pops the head at the edge. Show-ahead: head visible combinationally.
//  Push and pop in the same cycle: both take effect; count unchanged.
//  Credit rule guarantees no overflow. A push while full is a design error; a sim assertion flags it.
//  Pop when empty is ignored.
//  Redirect (highest priority), in cycle r:
//    - FIFO cleared; an inflight response arriving in cycle r is discarded; no request in cycle r.
//    - PC <= {redirect_pc[ADDR_W-1:2],2'b00} at the end of cycle r.
//    - The request for redirect_pc issues in r+1. Its data is valid in r+2 and pushed at the end of r+2.
//    - instr_valid=1 with the new instruction in r+3.
//    - A pop in cycle r is still consumed by decode but has no FIFO effect, since the FIFO is cleared anyway.
//  Latency: after reset release the first request goes out in cycle 0 and the word is pushed at the end of cycle 1.
//    instr_valid=1 in cycle 2. Steady state delivers 1 instr/cycle while instr_ready=1.
//  Backpressure: with instr_ready=0, requests stop once count+inflight=DEPTH. The queue fills to exactly DEPTH.
//    No word is lost or duplicated.
//  Reset asserted mid-operation: all state returns to its reset value immediately; in-flight data is dropped.
// STRUCTURE
//  Shared package fetch_pkg: ADDR_W, DATA_W, RESET_PC, PC_STEP=4, NOP=32'h0 constants.
//  Sub-module fetch_fifo: sync FIFO, DEPTH x (DATA_W+ADDR_W).
//    Ports: push, pop, flush, din, dout, count, empty, full. Pointers wrap mod DEPTH.
//  Top level holds PC, inflight flag, request/credit logic, and redirect priority.
// TESTING
//  1 Reset release, ready=1, imem returns addr>>2 -> instr_valid from cycle 2; pc_out 0,4,8,... one per cycle.
//  2 ready=0 for 10 cycles -> imem_req drops after 4 issued; buf_count=4.
//    Then ready=1 -> pc_out 0,4,8,12,16 in order, no gaps/dups.
//  3 redirect_valid at cycle 5, redirect_pc=32'h100 -> queue flushes, cycle-5 response dropped.
//    imem_addr=0x100 in cycle 6; instr_valid with pc_out=0x100 in cycle 8.
//  4 redirect_pc=32'h103 -> fetch address 0x100; 2 back-to-back redirects use the last target only.
//  5 Alternate ready 1/0 with random redirects for 2000 cycles.
//    Scoreboard: every popped pc_out follows the sequential/redirect model; count never >DEPTH.
//  6 rst_fb pulsed mid-stream (between edges) -> outputs zero at once; restart at RESET_PC as in test 1.
//  7 PC=32'hFFFF_FFFC -> next request address wraps to 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the fetch stage and its prefetch queue.
//   ADDR_W   : PC / instruction-memory address width
//   DATA_W   : instruction width
//   RESET_PC : PC loaded while reset is asserted
//   PC_STEP  : byte distance between sequential instructions
//   NOP      : value presented on instr_out while the queue is empty
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int          ADDR_W   = 32;
   localparam int          DATA_W   = 32;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;
   localparam logic [31:0] NOP      = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous show-ahead FIFO holding {instruction, pc} pairs.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   push     : write din at the edge (caller guarantees not full)
//   pop      : drop the head at the edge; ignored while empty
//   flush    : clear the queue; overrides push and pop
//   din      : entry to write
//   dout     : current head entry (raw storage while empty)
//   count    : occupancy, 0..DEPTH
//   empty    : count == 0
//   full     : count == DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty = (count_r == {CW{1'b0}});
   assign full  = (count_r == CW'(DEPTH));
   assign count = count_r;
   assign dout  = mem_r[rd_ptr_r];

   // Flush wins; a pop on an empty queue must not move the read pointer.
   assign do_push_s = push && !flush;
   assign do_pop_s  = pop && !flush && !empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is 2^PW.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         wr_ptr_r <= do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
         rd_ptr_r <= do_pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents are only observed through count-qualified reads.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

endmodule : fetch_fifo

// File: rtl/fetch_fifo_chk.sv
// ---------------------------------------------------------------------------
// fetch_fifo_chk
// Simulation checker for the prefetch queue: the request credit scheme must
// never let a response land in a full queue, and occupancy never exceeds DEPTH.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (checks disabled in reset)
//   push     : queue write this cycle
//   flush    : queue cleared this cycle
//   full     : queue full
//   count    : queue occupancy
// ---------------------------------------------------------------------------
module fetch_fifo_chk
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   flush,
   input  logic                   full,
   input  logic [$clog2(DEPTH):0] count
);

   localparam int CW = $clog2(DEPTH) + 1;

   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      !(push && full && !flush));

   a_count_in_range : assert property (@(posedge clk) disable iff (rst)
      count <= CW'(DEPTH));

endmodule : fetch_fifo_chk

// File: rtl/fetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_buffer
// Fetch stage: owns the PC, streams sequential reads into a 1-cycle-latency
// instruction memory, queues returned words with their PC and hands them to
// decode over valid/ready. A redirect flushes the queue and any read in flight.
// Ports:
//   clk_fb, rst_fb  : clock, asynchronous active-high reset
//   imem_req        : read request this cycle
//   imem_addr       : read address (current PC, word aligned)
//   imem_rdata      : read data, valid the cycle after imem_req
//   redirect_valid  : taken branch/jump this cycle
//   redirect_pc     : redirect target; low two bits dropped
//   instr_out       : head instruction (NOP while empty)
//   pc_out          : PC of head instruction (0 while empty)
//   instr_valid     : queue non-empty
//   instr_ready     : decode accepts the head this cycle
//   buf_count       : queue occupancy
// ---------------------------------------------------------------------------
module fetch_prefetch_buffer
   import fetch_pkg::*;
#(
   parameter int                          DEPTH    = 4,
   parameter int                          ADDR_W   = fetch_pkg::ADDR_W,
   parameter int                          DATA_W   = fetch_pkg::DATA_W,
   parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic                   clk_fb,
   input  logic                   rst_fb,
   output logic                   imem_req,
   output logic [ADDR_W-1:0]      imem_addr,
   input  logic [DATA_W-1:0]      imem_rdata,
   input  logic                   redirect_valid,
   input  logic [ADDR_W-1:0]      redirect_pc,
   output logic [DATA_W-1:0]      instr_out,
   output logic [ADDR_W-1:0]      pc_out,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [$clog2(DEPTH):0] buf_count
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = DATA_W + ADDR_W;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] PC_INIT    = ADDR_W'(RESET_PC);
   localparam logic [CW:0]       CREDIT_MAX = (CW+1)'(DEPTH);

   logic [ADDR_W-1:0] pc_r;
   logic [ADDR_W-1:0] req_pc_r;
   logic              inflight_r;
   logic              req_s;
   logic              push_s;
   logic              pop_s;
   logic [CW:0]       credit_used_s;
   logic [EW-1:0]     fifo_din_s;
   logic [EW-1:0]     fifo_dout_s;
   logic [CW-1:0]     fifo_count_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;

   // Slots already spoken for: queued words plus the one response that may be on its way.
   assign credit_used_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r};

   // Request only when a queue slot is guaranteed for the returning word;
   // redirect cycles and reset never request.
   always_comb begin
      req_s = 1'b0;
      if (rst_fb) begin
         req_s = 1'b0;
      end else if (redirect_valid) begin
         req_s = 1'b0;
      end else begin
         req_s = (credit_used_s < CREDIT_MAX);
      end
   end

   // A response arriving in a redirect cycle belongs to the abandoned path.
   assign push_s     = inflight_r && !redirect_valid;
   assign pop_s      = instr_valid && instr_ready;
   assign fifo_din_s = {imem_rdata, req_pc_r};

   // PC, PC of the outstanding read, and the in-flight flag.
   always_ff @(posedge clk_fb or posedge rst_fb) begin
      if (rst_fb) begin
         pc_r       <= PC_INIT;
         req_pc_r   <= PC_INIT;
         inflight_r <= 1'b0;
      end else begin
         inflight_r <= req_s;
         req_pc_r   <= req_s ? pc_r : req_pc_r;
         if (redirect_valid) begin
            pc_r <= redirect_pc & ALIGN_MASK;
         end else if (req_s) begin
            pc_r <= pc_r + STEP;
         end else begin
            pc_r <= pc_r;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (clk_fb),
      .rst   (rst_fb),
      .push  (push_s),
      .pop   (pop_s),
      .flush (redirect_valid),
      .din   (fifo_din_s),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   fetch_fifo_chk #(
      .DEPTH (DEPTH)
   ) u_fifo_chk (
      .clk   (clk_fb),
      .rst   (rst_fb),
      .push  (push_s),
      .flush (redirect_valid),
      .full  (fifo_full_s),
      .count (fifo_count_s)
   );

   assign imem_req    = req_s;
   assign imem_addr   = pc_r;
   assign instr_valid = !fifo_empty_s;
   assign buf_count   = fifo_count_s;
   // Present clean zeros while empty so stale storage never leaks to decode.
   assign instr_out   = fifo_empty_s ? DATA_W'(NOP) : fifo_dout_s[EW-1:ADDR_W];
   assign pc_out      = fifo_empty_s ? {ADDR_W{1'b0}} : fifo_dout_s[ADDR_W-1:0];

endmodule : fetch_prefetch_buffer

// File: tb/tb_fetch_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_buffer
// Directed bench for fetch_prefetch_buffer. The instruction memory model
// returns addr>>2 one cycle after a request. Inputs change 2 time units after
// each rising edge and outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_buffer;

   logic        clk_fb = 1'b0;
   logic        rst_fb;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  buf_count;

   int          checks = 0;
   int          errors = 0;
   int          pops   = 0;
   logic [31:0] exp_pc;
   logic        rnd_rv;
   logic [31:0] rnd_pc;

   always #5 clk_fb = ~clk_fb;

   fetch_prefetch_buffer #(
      .DEPTH    (4),
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk_fb         (clk_fb),
      .rst_fb         (rst_fb),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .buf_count      (buf_count)
   );

   // Synchronous instruction memory: word at addr is addr>>2; poison when idle.
   always @(posedge clk_fb) begin
      imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle, apply inputs, settle.
   task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc);
      @(posedge clk_fb);
      #2;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
   endtask

   // Hold reset two edges, release; returns settled inside cycle 0.
   task automatic do_reset(input logic rdy);
      rst_fb         = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      instr_ready    = rdy;
      repeat (2) @(posedge clk_fb);
      #2;
      rst_fb = 1'b0;
      #1;
   endtask

   initial begin
      rst_fb         = 1'b1;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      repeat (3) @(posedge clk_fb);
      #3;
      chk("rst_req",   imem_req,    64'd0);
      chk("rst_valid", instr_valid, 64'd0);
      chk("rst_count", buf_count,   64'd0);
      chk("rst_addr",  imem_addr,   64'd0);
      chk("rst_pc",    pc_out,      64'd0);
      chk("rst_instr", instr_out,   64'd0);

      // Test 1: first request in cycle 0, valid from cycle 2, one per cycle.
      @(posedge clk_fb);
      #2;
      rst_fb = 1'b0;
      #1;
      chk("t1_c0_req",   imem_req,    64'd1);
      chk("t1_c0_addr",  imem_addr,   64'd0);
      chk("t1_c0_valid", instr_valid, 64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t1_c1_addr",  imem_addr,   64'd4);
      chk("t1_c1_valid", instr_valid, 64'd0);
      for (int k = 2; k < 8; k++) begin
         cyc(1'b1, 1'b0, 32'h0);
         chk("t1_valid", instr_valid, 64'd1);
         chk("t1_pc",    pc_out,      64'(4 * (k - 2)));
         chk("t1_instr", instr_out,   64'(k - 2));
         chk("t1_count", buf_count,   64'd1);
      end

      // Test 2: backpressure; exactly four requests, queue fills to four.
      do_reset(1'b0);
      for (int c = 1; c < 10; c++) begin
         cyc(1'b0, 1'b0, 32'h0);
         if (c == 3) begin
            chk("t2_c3_req",  imem_req,  64'd1);
            chk("t2_c3_addr", imem_addr, 64'd12);
         end
         if (c == 4) chk("t2_c4_req", imem_req, 64'd0);
         if (c >= 5) begin
            chk("t2_full_count", buf_count, 64'd4);
            chk("t2_full_req",   imem_req,  64'd0);
            chk("t2_full_head",  pc_out,    64'd0);
         end
      end
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 32'h0);
         chk("t2_drain_valid", instr_valid, 64'd1);
         chk("t2_drain_pc",    pc_out,      64'(4 * k));
         chk("t2_drain_instr", instr_out,   64'(k));
      end

      // Test 3: redirect in cycle 5 to 0x100.
      do_reset(1'b1);
      repeat (4) cyc(1'b1, 1'b0, 32'h0);
      chk("t3_c4_pc", pc_out, 64'd8);
      cyc(1'b1, 1'b1, 32'h0000_0100);
      chk("t3_c5_req", imem_req, 64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t3_c6_req",   imem_req,    64'd1);
      chk("t3_c6_addr",  imem_addr,   64'h100);
      chk("t3_c6_valid", instr_valid, 64'd0);
      chk("t3_c6_count", buf_count,   64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t3_c7_valid", instr_valid, 64'd0);
      chk("t3_c7_addr",  imem_addr,   64'h104);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t3_c8_valid", instr_valid, 64'd1);
      chk("t3_c8_pc",    pc_out,      64'h100);
      chk("t3_c8_instr", instr_out,   64'h40);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t3_c9_pc",    pc_out,      64'h104);

      // Test 4: back-to-back redirects, last target (unaligned 0x103) wins.
      cyc(1'b1, 1'b1, 32'h0000_0208);
      cyc(1'b1, 1'b1, 32'h0000_0103);
      chk("t4_r1_req",  imem_req,  64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t4_r2_req",  imem_req,  64'd1);
      chk("t4_r2_addr", imem_addr, 64'h100);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t4_r3_valid", instr_valid, 64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t4_r4_valid", instr_valid, 64'd1);
      chk("t4_r4_pc",    pc_out,      64'h100);
      chk("t4_r4_instr", instr_out,   64'h40);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t4_r5_pc",    pc_out,      64'h104);

      // Test 7: PC wraps past the top of the address space.
      cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t7_addr_top",  imem_addr, 64'hFFFF_FFFC);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t7_addr_wrap", imem_addr, 64'd0);
      chk("t7_req_wrap",  imem_req,  64'd1);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t7_pc_top",    pc_out,    64'hFFFF_FFFC);
      chk("t7_instr_top", instr_out, 64'h3FFF_FFFF);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t7_pc_wrap",   pc_out,    64'd0);
      chk("t7_instr_wrap", instr_out, 64'd0);

      // Test 5: alternating ready with random redirects, checked against a
      // sequential-stream model restarted at each redirect target.
      exp_pc = 32'h0;
      for (int i = 0; i < 2000; i++) begin
         rnd_rv = (i == 0) || ($urandom_range(0, 15) == 0);
         rnd_pc = $urandom;
         cyc((i % 2) == 0, rnd_rv, rnd_pc);
         chk("t5_count_le_depth", 64'(buf_count <= 3'd4), 64'd1);
         if (rnd_rv) begin
            chk("t5_no_req_on_redirect", imem_req, 64'd0);
            exp_pc = rnd_pc & 32'hFFFF_FFFC;
         end else if (instr_valid && instr_ready) begin
            chk("t5_sb_pc",    pc_out,    64'(exp_pc));
            chk("t5_sb_instr", instr_out, 64'(exp_pc >> 2));
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
      end
      chk("t5_progress", 64'(pops > 200), 64'd1);

      // Test 6: reset pulsed between edges mid-stream.
      repeat (4) cyc(1'b1, 1'b0, 32'h0);
      chk("t6_pre_valid", instr_valid, 64'd1);
      rst_fb = 1'b1;
      #1;
      chk("t6_valid", instr_valid, 64'd0);
      chk("t6_req",   imem_req,    64'd0);
      chk("t6_count", buf_count,   64'd0);
      chk("t6_pc",    pc_out,      64'd0);
      chk("t6_instr", instr_out,   64'd0);
      chk("t6_addr",  imem_addr,   64'd0);
      @(posedge clk_fb);
      #2;
      rst_fb = 1'b0;
      #1;
      chk("t6_c0_req",  imem_req,  64'd1);
      chk("t6_c0_addr", imem_addr, 64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t6_c1_valid", instr_valid, 64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t6_c2_valid", instr_valid, 64'd1);
      chk("t6_c2_pc",    pc_out,      64'd0);
      cyc(1'b1, 1'b0, 32'h0);
      chk("t6_c3_pc",    pc_out,      64'd4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_fetch_prefetch_buffer
